wr_decode_scoreboard: RTL and testbench



---
 rtl/wr_decode_scoreboard_pkg.sv | 23 ++
 rtl/wr_decode_scoreboard_if.sv | 34 +++
 rtl/wr_decode_scoreboard_onehot_decoder.sv | 19 +
 rtl/wr_decode_scoreboard.sv | 88 ++++++++
 tb/tb_wr_decode_scoreboard.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/wr_decode_scoreboard_pkg.sv
// Shared widths and the one-hot helper for the write-back decoder and its reference models.
package wr_decode_scoreboard_pkg;

    localparam int ADDR_W_DEF   = 4;
    localparam int DATA_W_DEF   = 16;
    localparam int NUM_REGS_DEF = 1 << ADDR_W_DEF;

    function automatic int num_regs(input int addr_w);
        return 1 << addr_w;
    endfunction

    // Reference one-hot encode at the default width; en=0 yields all zeros.
    function automatic logic [NUM_REGS_DEF-1:0] onehot(input logic [ADDR_W_DEF-1:0] addr,
                                                        input logic                  en);
        logic [NUM_REGS_DEF-1:0] v;
        v = '0;
        if (en) begin
            v[addr] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/wr_decode_scoreboard_if.sv
// Issue, write-back, forwarding and scoreboard signals between the pipeline and the decoder.
interface wr_decode_scoreboard_if
    import wr_decode_scoreboard_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    localparam int NUM_REGS = 1 << ADDR_W;

    logic                issue_valid;
    logic [ADDR_W-1:0]   issue_rd;
    logic                issue_ready;
    logic                wb_valid;
    logic [ADDR_W-1:0]   wb_rd;
    logic [DATA_W-1:0]   wb_data;
    logic [NUM_REGS-1:0] wordline;
    logic [DATA_W-1:0]   wr_data;
    logic [ADDR_W-1:0]   rs_addr;
    logic                fwd_hit;
    logic [DATA_W-1:0]   fwd_data;
    logic [NUM_REGS-1:0] busy;
    logic                wb_err;

    modport master (
        output issue_valid, issue_rd, wb_valid, wb_rd, wb_data, rs_addr,
        input  issue_ready, wordline, wr_data, fwd_hit, fwd_data, busy, wb_err
    );

    modport slave (
        input  issue_valid, issue_rd, wb_valid, wb_rd, wb_data, rs_addr,
        output issue_ready, wordline, wr_data, fwd_hit, fwd_data, busy, wb_err
    );

endinterface

// File: rtl/wr_decode_scoreboard_onehot_decoder.sv
// Combinational address-to-one-hot decoder with enable; generalises the old 4-to-16 decoder.
module onehot_decoder
    import wr_decode_scoreboard_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0]        i_addr,
    input  logic                     i_en,
    output logic [(1<<ADDR_W)-1:0]   o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_addr] = 1'b1;
        end
    end

endmodule

// File: rtl/wr_decode_scoreboard.sv
// Write-back decoder: registered one-hot wordline, pending-write scoreboard with WAW stall,
// and single-port forwarding of the staged write.
module wr_decode_scoreboard
    import wr_decode_scoreboard_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wr_decode_scoreboard_if.slave bus
);

    localparam int NUM_REGS = 1 << ADDR_W;

    logic                w_wb_zero;
    logic                w_issue_zero;
    logic                w_rs_zero;
    logic                w_issue_ready;
    logic                w_set_en;
    logic                w_wb_err_set;
    logic                w_fwd_hit;
    logic [NUM_REGS-1:0] w_clr;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_busy_next;

    logic [NUM_REGS-1:0] r_busy;
    logic                r_wb_err;
    logic [NUM_REGS-1:0] r_wordline_p1;
    logic [DATA_W-1:0]   r_wr_data_p1;

    assign w_wb_zero    = ZERO_REG && (bus.wb_rd == '0);
    assign w_issue_zero = ZERO_REG && (bus.issue_rd == '0);
    assign w_rs_zero    = ZERO_REG && (bus.rs_addr == '0);

    // Write-backs to the hardwired zero register never produce a wordline or clear.
    onehot_decoder #(.ADDR_W(ADDR_W)) u_clr_dec (
        .i_addr   (bus.wb_rd),
        .i_en     (bus.wb_valid & ~w_wb_zero),
        .o_onehot (w_clr)
    );

    // A write-back landing this cycle frees its register for a same-cycle issue.
    assign w_issue_ready = bus.issue_valid
                         & (~r_busy[bus.issue_rd] | w_clr[bus.issue_rd] | w_issue_zero);
    assign w_set_en      = w_issue_ready & ~w_issue_zero;

    onehot_decoder #(.ADDR_W(ADDR_W)) u_set_dec (
        .i_addr   (bus.issue_rd),
        .i_en     (w_set_en),
        .o_onehot (w_set)
    );

    // Set is OR'd in last so a new writer keeps the register busy over a retiring one.
    assign w_busy_next  = (r_busy & ~w_clr) | w_set;
    assign w_wb_err_set = bus.wb_valid & ~r_busy[bus.wb_rd] & ~w_wb_zero;

    // Stage p0 -> p1: scoreboard update and write staging.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy        <= '0;
            r_wb_err      <= 1'b0;
            r_wordline_p1 <= '0;
            r_wr_data_p1  <= '0;
        end else begin
            r_busy        <= w_busy_next;
            r_wordline_p1 <= w_clr;
            if (w_wb_err_set) begin
                r_wb_err <= 1'b1;
            end
            if (bus.wb_valid) begin
                r_wr_data_p1 <= bus.wb_data;
            end
        end
    end

    assign w_fwd_hit = (|r_wordline_p1) & r_wordline_p1[bus.rs_addr] & ~w_rs_zero;

    assign bus.issue_ready = w_issue_ready;
    assign bus.wordline    = r_wordline_p1;
    assign bus.wr_data     = r_wr_data_p1;
    assign bus.fwd_hit     = w_fwd_hit;
    assign bus.fwd_data    = w_fwd_hit ? r_wr_data_p1 : '0;
    assign bus.busy        = r_busy;
    assign bus.wb_err      = r_wb_err;

endmodule

// File: tb/tb_wr_decode_scoreboard.sv
// Bench for wr_decode_scoreboard: vector table for issue/scoreboard/forwarding plus
// hand-written reset and address-sweep sequences, with a queue of expected staged writes.
module tb_wr_decode_scoreboard;
    import wr_decode_scoreboard_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    wr_decode_scoreboard_if #(.ADDR_W(4), .DATA_W(16)) bus ();

    wr_decode_scoreboard #(.ADDR_W(4), .DATA_W(16), .ZERO_REG(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        iv;
        logic [3:0]  ird;
        logic        wv;
        logic [3:0]  wrd;
        logic [15:0] wd;
        logic [3:0]  rs;
        logic        exp_ready;
        logic [15:0] exp_busy;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [15:0] wl;
        logic [15:0] data;
    } stage_t;

    stage_t      sb_q[$];
    vec_t        tbl[16];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [15:0] exp_hold  = '0;
    logic [15:0] last_wl   = '0;
    logic [15:0] last_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    // Drive one cycle of inputs at the falling edge and queue the staged write it implies.
    task automatic drive(input logic iv, input logic [3:0] ird, input logic wv,
                         input logic [3:0] wrd, input logic [15:0] wd, input logic [3:0] rs);
        stage_t e;
        @(negedge clk);
        bus.issue_valid = iv;
        bus.issue_rd    = ird;
        bus.wb_valid    = wv;
        bus.wb_rd       = wrd;
        bus.wb_data     = wd;
        bus.rs_addr     = rs;
        if (wv) exp_hold = wd;
        e.wl   = onehot(wrd, wv && (wrd != 4'd0));
        e.data = exp_hold;
        sb_q.push_back(e);
    endtask

    task automatic edge_check(input string tag);
        stage_t e;
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk({tag, "_wordline"}, bus.wordline, e.wl);
        chk({tag, "_wr_data"}, bus.wr_data, e.data);
        chk({tag, "_onehot0"}, {31'd0, $onehot0(bus.wordline)}, 32'd1);
        last_wl   = e.wl;
        last_data = e.data;
    endtask

    task automatic fwd_check(input string tag, input logic [3:0] rs);
        logic exp_hit;
        exp_hit = (last_wl != 16'd0) && last_wl[rs] && (rs != 4'd0);
        chk({tag, "_fwd_hit"}, {31'd0, bus.fwd_hit}, {31'd0, exp_hit});
        chk({tag, "_fwd_data"}, bus.fwd_data, exp_hit ? last_data : 16'd0);
    endtask

    initial begin
        //              iv ird   wv wrd   wd        rs    rdy busy       err
        tbl[0]  = '{1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 4'd0, 1'b0, 16'h0000, 1'b0};
        tbl[1]  = '{1'b1, 4'd5, 1'b0, 4'd0, 16'h0000, 4'd0, 1'b1, 16'h0020, 1'b0};
        tbl[2]  = '{1'b0, 4'd0, 1'b1, 4'd5, 16'hBEEF, 4'd0, 1'b0, 16'h0000, 1'b0};
        tbl[3]  = '{1'b1, 4'd3, 1'b0, 4'd0, 16'h0000, 4'd5, 1'b1, 16'h0008, 1'b0};
        tbl[4]  = '{1'b1, 4'd3, 1'b0, 4'd0, 16'h0000, 4'd0, 1'b0, 16'h0008, 1'b0};
        tbl[5]  = '{1'b1, 4'd3, 1'b1, 4'd3, 16'h3333, 4'd0, 1'b1, 16'h0008, 1'b0};
        tbl[6]  = '{1'b1, 4'd7, 1'b1, 4'd3, 16'h4444, 4'd3, 1'b1, 16'h0080, 1'b0};
        tbl[7]  = '{1'b0, 4'd0, 1'b1, 4'd7, 16'h1234, 4'd6, 1'b0, 16'h0000, 1'b0};
        tbl[8]  = '{1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 4'd7, 1'b0, 16'h0000, 1'b0};
        tbl[9]  = '{1'b1, 4'd0, 1'b0, 4'd0, 16'h0000, 4'd0, 1'b1, 16'h0000, 1'b0};
        tbl[10] = '{1'b0, 4'd0, 1'b1, 4'd0, 16'hFFFF, 4'd0, 1'b0, 16'h0000, 1'b0};
        tbl[11] = '{1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 4'd0, 1'b0, 16'h0000, 1'b0};
        tbl[12] = '{1'b0, 4'd0, 1'b1, 4'd9, 16'h9999, 4'd0, 1'b0, 16'h0000, 1'b1};
        tbl[13] = '{1'b0, 4'd0, 1'b0, 4'd0, 16'h0000, 4'd9, 1'b0, 16'h0000, 1'b1};
        tbl[14] = '{1'b1, 4'd9, 1'b1, 4'd9, 16'h5A5A, 4'd0, 1'b1, 16'h0200, 1'b1};
        tbl[15] = '{1'b1, 4'd2, 1'b1, 4'd9, 16'hA5A5, 4'd9, 1'b1, 16'h0004, 1'b1};

        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.wb_valid    = 1'b0;
        bus.wb_rd       = '0;
        bus.wb_data     = '0;
        bus.rs_addr     = '0;

        // Reset, then ten idle cycles.
        repeat (2) @(negedge clk);
        chk("rst_wordline", bus.wordline, 16'd0);
        chk("rst_busy", bus.busy, 16'd0);
        chk("rst_wb_err", {31'd0, bus.wb_err}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 4'd0, 1'b0, 4'd0, 16'h0, 4'd0);
            edge_check($sformatf("idle%0d", i));
            chk($sformatf("idle%0d_busy", i), bus.busy, 16'd0);
            chk($sformatf("idle%0d_wb_err", i), {31'd0, bus.wb_err}, 32'd0);
        end

        // Vector table: issue/stall/forward/zero-register/error cases.
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].iv, tbl[i].ird, tbl[i].wv, tbl[i].wrd, tbl[i].wd, tbl[i].rs);
            #1;
            chk($sformatf("v%0d_issue_ready", i), {31'd0, bus.issue_ready}, {31'd0, tbl[i].exp_ready});
            fwd_check($sformatf("v%0d", i), tbl[i].rs);
            edge_check($sformatf("v%0d", i));
            chk($sformatf("v%0d_busy", i), bus.busy, tbl[i].exp_busy);
            chk($sformatf("v%0d_wb_err", i), {31'd0, bus.wb_err}, {31'd0, tbl[i].exp_err});
        end

        // Async reset while a staged write is visible and another is in flight.
        drive(1'b0, 4'd0, 1'b1, 4'd4, 16'hAAAA, 4'd0);
        edge_check("ar_pre");
        @(negedge clk);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 4'd5;
        bus.wb_data  = 16'h5555;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_wordline", bus.wordline, 16'd0);
        chk("ar_wr_data", bus.wr_data, 16'd0);
        chk("ar_busy", bus.busy, 16'd0);
        chk("ar_wb_err", {31'd0, bus.wb_err}, 32'd0);
        bus.wb_valid = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        exp_hold  = '0;
        last_wl   = '0;
        last_data = '0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 4'd0, 1'b0, 4'd0, 16'h0, 4'd5);
            #1;
            fwd_check($sformatf("ar_post%0d", i), 4'd5);
            edge_check($sformatf("ar_post%0d", i));
        end

        // Back-to-back write-back sweep over every address.
        for (int a = 0; a < 16; a++) begin
            drive(1'b0, 4'd0, 1'b1, 4'(a), 16'(a * 16'h1111), 4'd0);
            edge_check($sformatf("sweep%0d", a));
        end
        drive(1'b0, 4'd0, 1'b0, 4'd0, 16'h0, 4'd15);
        #1;
        fwd_check("sweep_end", 4'd15);
        edge_check("sweep_end");
        chk("sweep_wb_err", {31'd0, bus.wb_err}, 32'd1);
        chk("sweep_busy", bus.busy, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
